spi_master_v3: RTL and testbench

SPI_MASTER_V3 -- requirements
Module: spi_master_v3

---
 rtl/spi_master_v3.sv | 231 +++++++++++++++++++++++
 tb/tb_spi_master_v3.sv | 211 +++++++++++++++++++++
 2 files changed

// File: rtl/spi_master_v3.sv
// SPI master: configurable CPOL/CPHA, divider, multi-word transfers and chip-select decode.
// Every output is a flop, loaded from the next-state logic alongside the FSM state.
module spi_master_v3 #(
  parameter int DATA_WIDTH = 8,
  parameter int NUM_CS     = 4,
  parameter int CS_W       = 2,
  parameter int DIV_W      = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic                  cpol,
  input  logic                  cpha,
  input  logic [DIV_W-1:0]      clk_div,
  input  logic [3:0]            xfer_len,
  input  logic [CS_W-1:0]       cs_sel,
  input  logic [DATA_WIDTH-1:0] tx_data,
  output logic                  tx_ready,
  output logic [DATA_WIDTH-1:0] rx_data,
  output logic                  rx_valid,
  output logic                  busy,
  output logic                  done,
  output logic                  sclk,
  output logic                  mosi,
  input  logic                  miso,
  output logic [NUM_CS-1:0]     cs_n
);

  localparam int EDGE_W = $clog2(2 * DATA_WIDTH);
  localparam logic [EDGE_W-1:0] LAST_EDGE = EDGE_W'(2 * DATA_WIDTH - 1);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    SETUP = 3'd1,
    XFER  = 3'd2,
    NEXT  = 3'd3,
    HOLD  = 3'd4,
    DONE  = 3'd5
  } state_t;

  state_t                state_r, state_s;
  logic [DIV_W-1:0]      div_r, div_s, cnt_r, cnt_s;
  logic [EDGE_W-1:0]     edge_r, edge_s;
  logic [3:0]            word_r, word_s, last_word_r, last_word_s;
  logic                  cpol_r, cpol_s, cpha_r, cpha_s;
  logic [DATA_WIDTH-1:0] tx_sh_r, tx_sh_s, rx_sh_r, rx_sh_s;
  logic [DATA_WIDTH-1:0] rx_data_s, rx_word_s;
  logic [NUM_CS-1:0]     cs_n_s;
  logic                  sclk_s, mosi_s, busy_s, done_s, tx_ready_s, rx_valid_s;
  logic                  lead_s, last_edge_s, sample_s, advance_s;

  // Out-of-range selects leave every line deasserted.
  function automatic logic [NUM_CS-1:0] cs_decode(input logic [CS_W-1:0] sel);
    logic [NUM_CS-1:0] m;
    m = {NUM_CS{1'b1}};
    for (int i = 0; i < NUM_CS; i++) begin
      m[i] = (32'(sel) == 32'(i)) ? 1'b0 : 1'b1;
    end
    return m;
  endfunction

  // Even edge indices are leading edges; the final trailing edge never advances mosi.
  assign lead_s      = ~edge_r[0];
  assign last_edge_s = (edge_r == LAST_EDGE);
  assign sample_s    = cpha_r ? ~lead_s : lead_s;
  assign advance_s   = cpha_r ? lead_s : (~lead_s & ~last_edge_s);
  assign rx_word_s   = cpha_r ? {rx_sh_r[DATA_WIDTH-2:0], miso} : rx_sh_r;

  // Next-state and next-output computation for the transfer FSM.
  always_comb begin
    state_s     = state_r;
    div_s       = div_r;
    cnt_s       = cnt_r;
    edge_s      = edge_r;
    word_s      = word_r;
    last_word_s = last_word_r;
    cpol_s      = cpol_r;
    cpha_s      = cpha_r;
    tx_sh_s     = tx_sh_r;
    rx_sh_s     = rx_sh_r;
    rx_data_s   = rx_data;
    cs_n_s      = cs_n;
    sclk_s      = sclk;
    mosi_s      = mosi;
    busy_s      = busy;
    done_s      = 1'b0;
    tx_ready_s  = 1'b0;
    rx_valid_s  = 1'b0;
    case (state_r)
      IDLE: begin
        if (start) begin
          state_s     = SETUP;
          cpol_s      = cpol;
          cpha_s      = cpha;
          div_s       = clk_div;
          last_word_s = (xfer_len == 4'd0) ? 4'd0 : (xfer_len - 4'd1);
          word_s      = 4'd0;
          cnt_s       = {DIV_W{1'b0}};
          cs_n_s      = cs_decode(cs_sel);
          busy_s      = 1'b1;
          sclk_s      = cpol;
          if (cpha) begin
            tx_sh_s = tx_data;
            mosi_s  = 1'b0;
          end else begin
            tx_sh_s = {tx_data[DATA_WIDTH-2:0], 1'b0};
            mosi_s  = tx_data[DATA_WIDTH-1];
          end
        end else begin
          state_s = IDLE;
        end
      end
      SETUP: begin
        if (cnt_r == div_r) begin
          state_s = XFER;
          cnt_s   = {DIV_W{1'b0}};
          edge_s  = {EDGE_W{1'b0}};
        end else begin
          cnt_s = cnt_r + DIV_W'(1'b1);
        end
      end
      XFER: begin
        if (cnt_r == div_r) begin
          cnt_s  = {DIV_W{1'b0}};
          sclk_s = ~sclk;
          if (sample_s) begin
            rx_sh_s = {rx_sh_r[DATA_WIDTH-2:0], miso};
          end else begin
            rx_sh_s = rx_sh_r;
          end
          if (advance_s) begin
            mosi_s  = tx_sh_r[DATA_WIDTH-1];
            tx_sh_s = {tx_sh_r[DATA_WIDTH-2:0], 1'b0};
          end else begin
            tx_sh_s = tx_sh_r;
          end
          if (last_edge_s) begin
            rx_data_s  = rx_word_s;
            rx_valid_s = 1'b1;
            if (word_r == last_word_r) begin
              state_s = HOLD;
            end else begin
              state_s    = NEXT;
              tx_ready_s = 1'b1;
            end
          end else begin
            edge_s = edge_r + EDGE_W'(1'b1);
          end
        end else begin
          cnt_s = cnt_r + DIV_W'(1'b1);
        end
      end
      NEXT: begin
        state_s = XFER;
        word_s  = word_r + 4'd1;
        cnt_s   = {DIV_W{1'b0}};
        edge_s  = {EDGE_W{1'b0}};
        if (cpha_r) begin
          tx_sh_s = tx_data;
        end else begin
          tx_sh_s = {tx_data[DATA_WIDTH-2:0], 1'b0};
          mosi_s  = tx_data[DATA_WIDTH-1];
        end
      end
      HOLD: begin
        if (cnt_r == div_r) begin
          state_s = DONE;
          cs_n_s  = {NUM_CS{1'b1}};
          busy_s  = 1'b0;
          done_s  = 1'b1;
        end else begin
          cnt_s = cnt_r + DIV_W'(1'b1);
        end
      end
      DONE: begin
        state_s = IDLE;
        mosi_s  = 1'b0;
      end
      default: begin
        state_s = IDLE;
        cs_n_s  = {NUM_CS{1'b1}};
        busy_s  = 1'b0;
        mosi_s  = 1'b0;
      end
    endcase
  end

  // State, datapath and output registers; reset aborts any transfer in flight.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r     <= IDLE;
      div_r       <= {DIV_W{1'b0}};
      cnt_r       <= {DIV_W{1'b0}};
      edge_r      <= {EDGE_W{1'b0}};
      word_r      <= 4'd0;
      last_word_r <= 4'd0;
      cpol_r      <= 1'b0;
      cpha_r      <= 1'b0;
      tx_sh_r     <= {DATA_WIDTH{1'b0}};
      rx_sh_r     <= {DATA_WIDTH{1'b0}};
      rx_data     <= {DATA_WIDTH{1'b0}};
      cs_n        <= {NUM_CS{1'b1}};
      sclk        <= 1'b0;
      mosi        <= 1'b0;
      busy        <= 1'b0;
      done        <= 1'b0;
      tx_ready    <= 1'b0;
      rx_valid    <= 1'b0;
    end else begin
      state_r     <= state_s;
      div_r       <= div_s;
      cnt_r       <= cnt_s;
      edge_r      <= edge_s;
      word_r      <= word_s;
      last_word_r <= last_word_s;
      cpol_r      <= cpol_s;
      cpha_r      <= cpha_s;
      tx_sh_r     <= tx_sh_s;
      rx_sh_r     <= rx_sh_s;
      rx_data     <= rx_data_s;
      cs_n        <= cs_n_s;
      sclk        <= sclk_s;
      mosi        <= mosi_s;
      busy        <= busy_s;
      done        <= done_s;
      tx_ready    <= tx_ready_s;
      rx_valid    <= rx_valid_s;
    end
  end

endmodule

// File: tb/tb_spi_master_v3.sv
// Directed bench for spi_master_v3: mode 0..3 transfers, multi-word, chip-select decode,
// word-count limits, mid-transfer reset and start/config changes while busy.
module tb_spi_master_v3;

  logic       clk = 1'b0;
  logic       rst, start, cpol, cpha, miso;
  logic [7:0] clk_div;
  logic [3:0] xfer_len;
  logic [1:0] cs_sel;
  logic [7:0] tx_data;
  logic       tx_ready, rx_valid, busy, done, sclk, mosi;
  logic [7:0] rx_data;
  logic [3:0] cs_n;

  int checks = 0;
  int errors = 0;

  int         r_cyc, r_tog, r_rxv, r_txr, r_csbad, bad;
  bit         r_to;
  logic [7:0] r_rx [16];
  logic [7:0] r_mcap;
  logic [7:0] tx_list [16];

  spi_master_v3 dut (
    .clk(clk), .rst(rst), .start(start), .cpol(cpol), .cpha(cpha),
    .clk_div(clk_div), .xfer_len(xfer_len), .cs_sel(cs_sel), .tx_data(tx_data),
    .tx_ready(tx_ready), .rx_data(rx_data), .rx_valid(rx_valid), .busy(busy),
    .done(done), .sclk(sclk), .mosi(mosi), .miso(miso), .cs_n(cs_n)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Runs one transfer from an IDLE negedge; slave is loopback or a mode-0 shifter of sword.
  task automatic run_xfer(input logic c_pol, input logic c_pha, input logic [7:0] div,
                          input logic [3:0] len, input logic [1:0] sel, input logic [3:0] exp_cs,
                          input bit loopback, input logic [7:0] sword, input bit hold_start,
                          input int abort_tog);
    logic prev_busy, prev_sclk, lead;
    int   idx;
    bit   fin;
    r_cyc = 0; r_tog = 0; r_rxv = 0; r_txr = 0; r_csbad = 0; r_mcap = 8'h00;
    r_to = 1'b0; fin = 1'b0; idx = 0;
    cpol = c_pol; cpha = c_pha; clk_div = div; xfer_len = len; cs_sel = sel;
    tx_data = tx_list[0];
    miso = loopback ? mosi : sword[7];
    prev_busy = 1'b0; prev_sclk = sclk;
    start = 1'b1;
    for (int k = 1; k <= 2000 && !fin; k++) begin
      @(negedge clk);
      if (!hold_start) start = 1'b0;
      else if (k == 10) begin
        cpol = ~c_pol; cs_sel = ~sel; clk_div = 8'd7;
      end
      if (busy && prev_busy && (sclk !== prev_sclk)) begin
        r_tog++;
        lead = (sclk !== c_pol);
        if (lead != c_pha) r_mcap = {r_mcap[6:0], mosi};
        if (!loopback && !lead) begin
          idx++;
          miso = (idx < 8) ? sword[7-idx] : 1'b0;
        end
      end
      if (busy ? (cs_n !== exp_cs) : (cs_n !== 4'hF)) r_csbad++;
      if (rx_valid) begin
        if (r_rxv < 16) r_rx[r_rxv] = rx_data;
        r_rxv++;
      end
      if (tx_ready) begin
        r_txr++;
        if (r_txr < 16) tx_data = tx_list[r_txr];
      end
      if (done) begin
        r_cyc = k + 1;
        fin = 1'b1;
      end
      if (loopback) miso = mosi;
      prev_busy = busy; prev_sclk = sclk;
      if (abort_tog != 0 && r_tog >= abort_tog) fin = 1'b1;
    end
    if (!fin) r_to = 1'b1;
    start = 1'b0;
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; cpol = 1'b0; cpha = 1'b0; clk_div = 8'd0;
    xfer_len = 4'd0; cs_sel = 2'd0; tx_data = 8'h00; miso = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_cs_n", cs_n, 4'hF);
    check("rst_sclk", sclk, 1'b0);
    check("rst_mosi", mosi, 1'b0);
    check("rst_busy", busy, 1'b0);
    check("rst_done", done, 1'b0);
    check("rst_tx_ready", tx_ready, 1'b0);
    check("rst_rx_valid", rx_valid, 1'b0);
    check("rst_rx_data", rx_data, 8'h00);
    rst = 1'b0;
    @(negedge clk);

    // Mode 0, H=2, slave returns 0x3C
    tx_list[0] = 8'hA5;
    run_xfer(1'b0, 1'b0, 8'd1, 4'd1, 2'd0, 4'b1110, 1'b0, 8'h3C, 1'b0, 0);
    check("m0_timeout", r_to, 1'b0);
    check("m0_done_cycle", r_cyc, 38);
    check("m0_rx_data", r_rx[0], 8'h3C);
    check("m0_rx_valid_cnt", r_rxv, 1);
    check("m0_mosi_bits", r_mcap, 8'hA5);
    check("m0_toggles", r_tog, 16);
    check("m0_cs_n", r_csbad, 0);
    @(negedge clk);
    check("m0_idle_busy", busy, 1'b0);
    check("m0_idle_sclk", sclk, 1'b0);
    check("m0_idle_mosi", mosi, 1'b0);

    // Mode 3, H=1, three words via tx_ready, loopback
    tx_list[0] = 8'h01; tx_list[1] = 8'h80; tx_list[2] = 8'hFF;
    run_xfer(1'b1, 1'b1, 8'd0, 4'd3, 2'd1, 4'b1101, 1'b1, 8'h00, 1'b0, 0);
    check("m3_done_cycle", r_cyc, 54);
    check("m3_rx_valid_cnt", r_rxv, 3);
    check("m3_rx0", r_rx[0], 8'h01);
    check("m3_rx1", r_rx[1], 8'h80);
    check("m3_rx2", r_rx[2], 8'hFF);
    check("m3_toggles", r_tog, 48);
    check("m3_cs_n", r_csbad, 0);
    check("m3_tx_ready_cnt", r_txr, 2);
    @(negedge clk);
    check("m3_idle_sclk", sclk, 1'b1);
    check("m3_idle_mosi", mosi, 1'b0);

    // Mode 1 (H=3) and mode 2 (H=2) loopback
    tx_list[0] = 8'h5A;
    run_xfer(1'b0, 1'b1, 8'd2, 4'd1, 2'd2, 4'b1011, 1'b1, 8'h00, 1'b0, 0);
    check("m1_done_cycle", r_cyc, 56);
    check("m1_rx_data", r_rx[0], 8'h5A);
    check("m1_cs_n", r_csbad, 0);
    @(negedge clk);
    run_xfer(1'b1, 1'b0, 8'd1, 4'd1, 2'd0, 4'b1110, 1'b1, 8'h00, 1'b0, 0);
    check("m2_done_cycle", r_cyc, 38);
    check("m2_rx_data", r_rx[0], 8'h5A);
    check("m2_toggles", r_tog, 16);
    @(negedge clk);

    // xfer_len=0 behaves as one word; cs_sel=3
    tx_list[0] = 8'h3C;
    run_xfer(1'b0, 1'b0, 8'd1, 4'd0, 2'd3, 4'b0111, 1'b1, 8'h00, 1'b0, 0);
    check("len0_done_cycle", r_cyc, 38);
    check("len0_rx_valid_cnt", r_rxv, 1);
    check("len0_rx_data", r_rx[0], 8'h3C);
    check("len0_cs_n", r_csbad, 0);
    @(negedge clk);
    check("len0_idle_cs_n", cs_n, 4'hF);

    // xfer_len=15 gives exactly 15 words
    for (int i = 0; i < 16; i++) tx_list[i] = 8'(i * 17 + 3);
    run_xfer(1'b0, 1'b0, 8'd0, 4'd15, 2'd0, 4'b1110, 1'b1, 8'h00, 1'b0, 0);
    check("len15_done_cycle", r_cyc, 258);
    check("len15_rx_valid_cnt", r_rxv, 15);
    check("len15_rx7", r_rx[7], 8'h7A);
    check("len15_rx14", r_rx[14], 8'hF1);
    check("len15_tx_ready_cnt", r_txr, 14);
    @(negedge clk);

    // start held high and config changed while busy
    tx_list[0] = 8'h96;
    run_xfer(1'b0, 1'b0, 8'd1, 4'd1, 2'd0, 4'b1110, 1'b1, 8'h00, 1'b1, 0);
    check("hold_done_cycle", r_cyc, 38);
    check("hold_toggles", r_tog, 16);
    check("hold_rx_data", r_rx[0], 8'h96);
    check("hold_cs_n", r_csbad, 0);
    repeat (3) @(negedge clk);
    check("hold_idle_busy", busy, 1'b0);
    check("hold_idle_sclk", sclk, 1'b0);

    // Reset during bit 4 of word 2 (mode 2 so sclk idles high before reset)
    tx_list[0] = 8'h11; tx_list[1] = 8'h22; tx_list[2] = 8'h33;
    run_xfer(1'b1, 1'b0, 8'd1, 4'd3, 2'd0, 4'b1110, 1'b1, 8'h00, 1'b0, 24);
    check("abort_words_before", r_rxv, 1);
    check("abort_busy_before", busy, 1'b1);
    rst = 1'b1;
    #1;
    check("abort_cs_n", cs_n, 4'hF);
    check("abort_sclk", sclk, 1'b0);
    check("abort_mosi", mosi, 1'b0);
    check("abort_busy", busy, 1'b0);
    check("abort_rx_data", rx_data, 8'h00);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    bad = 0;
    repeat (40) begin
      @(negedge clk);
      if (done || rx_valid || busy) bad++;
    end
    check("abort_no_pulses", bad, 0);
    tx_list[0] = 8'hA5;
    run_xfer(1'b0, 1'b0, 8'd1, 4'd1, 2'd0, 4'b1110, 1'b0, 8'h3C, 1'b0, 0);
    check("after_abort_done_cycle", r_cyc, 38);
    check("after_abort_rx_data", r_rx[0], 8'h3C);
    @(negedge clk);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
